// File: rtl/v2f_combinator_pipe.sv
// Factorio arithmetic/decider combinator: 32-bit wrapping ALU and comparator
// feeding a LATENCY-deep result pipeline that advances only on game ticks.
module v2f_combinator_pipe #(
  parameter int LATENCY = 1,
  parameter bit SIGNED  = 1'b1
) (
  input  logic        CLK,
  input  logic        ARST,
  input  logic        TICK,
  input  logic        IN_VALID,
  input  logic [3:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        OUT_VALID,
  output logic [31:0] Y
);

  if ((LATENCY < 1) || (LATENCY > 8)) begin : g_bad_latency
    $error("v2f_combinator_pipe: LATENCY must be in 1..8");
  end

  // Division never traps: x/0 and x%0 read 0, and INT_MIN/-1 wraps back to INT_MIN.
  function automatic logic [31:0] f_divmod(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        signed_mode,
    input logic        want_mod
  );
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [31:0]        r;
    sa = $signed(a);
    sb = $signed(b);
    sq = 32'sd0;
    sr = 32'sd0;
    r  = 32'd0;
    if (b == 32'd0) begin
      r = 32'd0;
    end else if (signed_mode && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      r = want_mod ? 32'd0 : 32'h8000_0000;
    end else if (signed_mode) begin
      sq = sa / sb;
      sr = sa % sb;
      r  = want_mod ? sr : sq;
    end else begin
      r = want_mod ? (a % b) : (a / b);
    end
    return r;
  endfunction

  logic [4:0]         shamt_s;
  logic signed [31:0] sra_s;
  logic               lt_s;
  logic               gt_s;
  logic               eq_s;
  logic [31:0]        result_s;

  always_comb begin
    shamt_s  = B[4:0];
    sra_s    = $signed(A) >>> shamt_s;
    eq_s     = (A == B);
    if (SIGNED) begin
      lt_s = ($signed(A) < $signed(B));
      gt_s = ($signed(A) > $signed(B));
    end else begin
      lt_s = (A < B);
      gt_s = (A > B);
    end
    result_s = 32'd0;
    case (OP)
      4'd0:    result_s = A + B;
      4'd1:    result_s = A - B;
      4'd2:    result_s = A * B;
      4'd3:    result_s = f_divmod(A, B, SIGNED, 1'b0);
      4'd4:    result_s = f_divmod(A, B, SIGNED, 1'b1);
      4'd5:    result_s = A & B;
      4'd6:    result_s = A | B;
      4'd7:    result_s = A ^ B;
      4'd8:    result_s = A << shamt_s;
      4'd9:    result_s = SIGNED ? sra_s : (A >> shamt_s);
      4'd10:   result_s = {31'd0, gt_s};
      4'd11:   result_s = {31'd0, lt_s};
      4'd12:   result_s = {31'd0, ~lt_s};
      4'd13:   result_s = {31'd0, ~gt_s};
      4'd14:   result_s = {31'd0, eq_s};
      4'd15:   result_s = {31'd0, ~eq_s};
      default: result_s = 32'd0;
    endcase
  end

  logic [LATENCY-1:0]       vld_q;
  logic [LATENCY-1:0]       vld_d;
  logic [LATENCY-1:0][31:0] res_q;
  logic [LATENCY-1:0][31:0] res_d;

  // A bubble carries result 0 so an absent signal reads 0 at the output.
  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    if (TICK) begin
      vld_d[0] = IN_VALID;
      res_d[0] = IN_VALID ? result_s : 32'd0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        res_d[i] = res_q[i-1];
      end
    end else begin
      vld_d = vld_q;
      res_d = res_q;
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      vld_q <= '0;
      res_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
    end
  end

  assign OUT_VALID = vld_q[LATENCY-1];
  assign Y         = res_q[LATENCY-1];

endmodule
